uart_rx_v2_core: RTL
====================

Name: uart_rx_v2_core

Overview:
- UART receiver: 8 data bits, LSB first, no parity, 1 stop bit, idle-high line.
- Counterpart of the team's existing UART transmitter, at the same clk_freq/uart_freq parameterisation.
- Sits between the board RX pin and downstream byte consumers.
- Delivers each received byte with a one-cycle valid strobe and flags framing errors.

Parameters:
- clk_freq, 50000000: system clock frequency in Hz.
- uart_freq, 115200: baud rate in Hz.
- Derived, not overridable: BIT_CNT = clk_freq/uart_freq (integer division); HALF = BIT_CNT/2.
- Legal range: BIT_CNT >= 4. Elaboration-time error otherwise.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rx_p  input  1  asynchronous serial line; idle high.
- dout  output  8  last correctly framed byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse; dout is updated in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop-bit sample is 0.
- rx_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; dout = 8'h00; rx_valid = frame_err = 0; rx_busy = 0.
  - Synchroniser flops, edge-history flop and armed flag all preset to 1.
  - Bit counter and bit index cleared.
  - Reset overrides any frame in progress; the partial byte is discarded with no pulse.
- Input path: 2-flop synchroniser on rx_p gives rx_s. A third flop gives rx_d. Falling edge: fall = rx_d & ~rx_s.
- Single clock-cycle counter cnt, width ceil(log2(BIT_CNT))+1. cnt clears on every state change.
- IDLE:
  - If armed and fall: go to START.
  - armed is set whenever rx_s == 1 in IDLE.
- START: when cnt == HALF-1, sample rx_s.
  - 0: go to DATA, bit index = 0.
  - 1: glitch; return to IDLE with no output pulse.
- DATA: when cnt == BIT_CNT-1, sample rx_s into shift[bit index] (LSB first) and clear cnt.
  - After bit index 7 is sampled, go to STOP.
  - Samples fall mid-bit because START consumed HALF cycles.
- STOP: when cnt == BIT_CNT-1, sample rx_s.
  - 1: dout <= shift, rx_valid = 1 for exactly one cycle, go to IDLE.
  - 0: frame_err = 1 for one cycle, dout unchanged, armed = 0, go to IDLE.
  - With armed = 0, no new frame is accepted until rx_s has been seen high (break / stuck-low protection).
- Return to IDLE happens mid stop bit, so a start edge immediately after a 1-bit stop is caught (back-to-back frames).
- rx_valid and frame_err are never high in the same cycle.
- Latency: rx_valid asserts HALF + 9*BIT_CNT + 3..5 cycles after the rx_p falling edge. The 3..5 covers synchroniser, edge detect and output register; bench tolerance ±2 cycles.
- rx_p changes during DATA/STOP between sample points are ignored; only the mid-bit samples matter.
- Edge detection runs only in IDLE. Falling edges seen in other states are ignored.

Test Plan (sim parameters clk_freq=1000, uart_freq=100, so BIT_CNT=10, HALF=5, unless stated):
1. Send a 0x55 frame at 10 clk/bit -> exactly one rx_valid pulse, dout=0x55, frame_err never high, rx_busy low after the pulse.
2. Back-to-back 0xA5 then 0x3C, 1 stop bit each, no idle gap -> two rx_valid pulses ~100 cycles apart, dout 0xA5 then 0x3C.
3. rx_p low for 3 cycles, then high -> START aborts at its sample point. No rx_valid or frame_err; rx_busy high for ~7 cycles, then low.
4. First receive 0x12, then a 0xFF frame with stop bit driven 0, then hold rx_p low for 50 cycles:
   - Exactly one frame_err pulse; dout stays 0x12.
   - No new START while the line stays low.
   - After rx_p goes high, frame 0x81 is received correctly.
5. Drive rst_n low for 1 cycle during data bit 4 of frame 0xF0:
   - Next cycle: state IDLE, dout=0x00, no pulse.
   - A following 0x81 frame -> rx_valid, dout=0x81.
6. Default parameters, looped from the team's UART transmitter sending 0x00, 0xFF, 0x5A -> three rx_valid pulses with matching dout, zero frame_err.

Source files
------------

// File: rtl/uart_rx_v2_core.sv
// 8N1 UART receiver: synchronises rx_p, finds the start edge, samples each bit
// mid-period and emits one-cycle rx_valid / frame_err strobes.
module uart_rx_v2_core #(
  parameter int clk_freq  = 50000000,
  parameter int uart_freq = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_p,
  output logic [7:0] dout,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BIT_CNT = clk_freq / uart_freq;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CNT_W   = $clog2(BIT_CNT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);

  if (BIT_CNT < 4) begin : g_param_check
    $error("uart_rx_v2_core: clk_freq/uart_freq must be at least 4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               busy_q, busy_d;
  logic               armed_q, armed_d;
  logic               sync1_q, sync1_d;
  logic               rx_s_q, rx_s_d;
  logic               rx_d_q, rx_d_d;
  logic               fall;

  assign fall = rx_d_q & ~rx_s_q;

  always_comb begin
    sync1_d  = rx_p;
    rx_s_d   = sync1_q;
    rx_d_d   = rx_s_q;
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    armed_d  = armed_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s_q) armed_d = 1'b1;
        if (armed_q && fall) state_d = START;
      end
      START: begin
        // A start bit that is already high again at mid-bit was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        // Leave mid stop bit so a directly following start edge is not missed;
        // a low stop bit disarms until the line has been seen idle again.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
      armed_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
      rx_d_q  <= rx_d_d;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign dout      = dout_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule
